// File: rtl/parity_frame_rx.sv
// Serial parity-frame receiver: DATA_BITS data bits (LSB first) plus one parity bit.
// Define PARITY_FRAME_RX_ERRCNT_EN to build the saturating parity-error counter on err_cnt.
module parity_frame_rx #(
  parameter int DATA_BITS = 8,
  parameter int ODD       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_valid,
  input  logic                 sof,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  localparam int   CW      = $clog2(DATA_BITS + 1);
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic                 par, par_nxt;
  logic                 frame_done;
  logic                 check;

  // Handshake: there is no back-pressure. A bit (and its sof flag) is consumed
  // on every cycle with sin_valid=1; with sin_valid=0 all inputs are ignored.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    shift_nxt  = shift_reg;
    par_nxt    = par;
    frame_done = 1'b0;
    check      = par ^ sin ^ ODD_BIT;
    if (sin_valid) begin
      if (sof) begin
        // sof restarts from any state; an unfinished frame is silently dropped
        shift_nxt    = '0;
        shift_nxt[0] = sin;
        par_nxt      = sin;
        cnt_nxt      = CW'(1);
        state_nxt    = DATA;
      end else begin
        unique case (state)
          DATA: begin
            for (int i = 0; i < DATA_BITS; i++) begin
              if (cnt == CW'(i)) shift_nxt[i] = sin;
            end
            par_nxt = par ^ sin;
            cnt_nxt = cnt + CW'(1);
            if (cnt_nxt == CW'(DATA_BITS)) state_nxt = PARITY;
          end
          PARITY: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      par        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shift_reg  <= shift_nxt;
      par        <= par_nxt;
      busy       <= (state_nxt != IDLE);
      data_valid <= frame_done;
      if (frame_done) begin
        data_out   <= shift_reg;
        parity_err <= check;
      end
    end
  end

`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Counts in step with the data_valid pulse; sticks at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (frame_done && check && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx: an even-parity and an odd-parity instance share one stimulus stream.
module tb_parity_frame_rx;
  localparam int W = 8;

`ifdef PARITY_FRAME_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sof = 1'b0;

  logic [W-1:0] data_out_e, data_out_o;
  logic         data_valid_e, data_valid_o;
  logic         parity_err_e, parity_err_o;
  logic         busy_e, busy_o;
  logic [7:0]   err_cnt_e, err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt   = 0;
  int exp_ec_e = 0;
  int exp_ec_o = 0;
  logic [W-1:0] exp_q[$];

  parity_frame_rx #(.DATA_BITS(W), .ODD(0)) u_even (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .data_out(data_out_e), .data_valid(data_valid_e), .parity_err(parity_err_e),
    .busy(busy_e), .err_cnt(err_cnt_e)
  );

  parity_frame_rx #(.DATA_BITS(W), .ODD(1)) u_odd (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sof(sof),
    .data_out(data_out_o), .data_valid(data_valid_o), .parity_err(parity_err_o),
    .busy(busy_o), .err_cnt(err_cnt_o)
  );

  always @(negedge clk) if (data_valid_e === 1'b1) dv_cnt++;

  function automatic logic [7:0] ec(input int n);
    return ERRCNT ? 8'(n) : 8'd0;
  endfunction

  // ---------------- clock/reset and driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input logic s);
    sin = b; sin_valid = 1'b1; sof = s;
    tick();
    sin_valid = 1'b0; sof = 1'b0; sin = 1'($urandom_range(0, 1));
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      sin = 1'($urandom_range(0, 1));
      sof = 1'($urandom_range(0, 1));
      tick();
    end
    sof = 1'b0;
  endtask

  task automatic send_data(input logic [W-1:0] d);
    drive_bit(d[0], 1'b1);
    for (int i = 1; i < W; i++) drive_bit(d[i], 1'b0);
  endtask

  task automatic send_parity(input logic [W-1:0] d, input logic p);
    logic e;
    drive_bit(p, 1'b0);
    e = (^d) ^ p;
    if (e) begin if (exp_ec_e < 255) exp_ec_e++; end
    else   begin if (exp_ec_o < 255) exp_ec_o++; end
    exp_q.push_back(d);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (data_out_e !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out_e); end
    n_checks++; if (data_valid_e !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid_e); end
    n_checks++; if (parity_err_e !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err_e); end
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_e); end
    n_checks++; if (err_cnt_e !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt_e); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [W-1:0] exp;
    send_data(8'hA5);
    n_checks++; if (data_valid_e !== 1'b0 || busy_e !== 1'b1) begin n_fail++; $display("FAIL basic_pre_parity: got dv=%b busy=%b expected dv=0 busy=1", data_valid_e, busy_e); end
    send_parity(8'hA5, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (data_valid_e !== 1'b1) begin n_fail++; $display("FAIL basic_dv: got %b expected 1", data_valid_e); end
    n_checks++; if (data_out_e !== exp) begin n_fail++; $display("FAIL basic_data: got %h expected %h", data_out_e, exp); end
    n_checks++; if (parity_err_e !== 1'b0) begin n_fail++; $display("FAIL basic_perr: got %b expected 0", parity_err_e); end
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 0", busy_e); end
    tick();
    n_checks++; if (data_valid_e !== 1'b0) begin n_fail++; $display("FAIL basic_dv_width: got %b expected 0", data_valid_e); end
    n_checks++; if (data_out_e !== 8'hA5) begin n_fail++; $display("FAIL basic_data_hold: got %h expected a5", data_out_e); end
  endtask

  task automatic test_parity_error();
    logic [W-1:0] exp;
    send_data(8'h07);
    send_parity(8'h07, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (data_out_e !== exp) begin n_fail++; $display("FAIL perr_data: got %h expected %h", data_out_e, exp); end
    n_checks++; if (parity_err_e !== 1'b1) begin n_fail++; $display("FAIL perr_even_flag: got %b expected 1", parity_err_e); end
    n_checks++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL perr_odd_flag: got %b expected 0", parity_err_o); end
    tick();
    n_checks++; if (err_cnt_e !== (ERRCNT ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL perr_err_cnt: got %0d expected %0d", err_cnt_e, ERRCNT ? 1 : 0); end
    n_checks++; if (parity_err_e !== 1'b1) begin n_fail++; $display("FAIL perr_flag_hold: got %b expected 1", parity_err_e); end
  endtask

  task automatic test_gaps();
    logic [W-1:0] d;
    logic [W-1:0] exp;
    int c0;
    d = 8'h3C;
    c0 = dv_cnt;
    drive_bit(d[0], 1'b1);
    for (int i = 1; i <= W; i++) begin
      gap($urandom_range(1, 5));
      n_checks++; if (busy_e !== 1'b1) begin n_fail++; $display("FAIL gaps_busy bit %0d: got %b expected 1", i, busy_e); end
      n_checks++; if (data_valid_e !== 1'b0) begin n_fail++; $display("FAIL gaps_early_dv bit %0d: got %b expected 0", i, data_valid_e); end
      if (i < W) drive_bit(d[i], 1'b0);
    end
    send_parity(d, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (data_valid_e !== 1'b1) begin n_fail++; $display("FAIL gaps_dv: got %b expected 1", data_valid_e); end
    n_checks++; if (data_out_e !== exp) begin n_fail++; $display("FAIL gaps_data: got %h expected %h", data_out_e, exp); end
    n_checks++; if (parity_err_e !== 1'b0) begin n_fail++; $display("FAIL gaps_perr: got %b expected 0", parity_err_e); end
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL gaps_busy_done: got %b expected 0", busy_e); end
    tick();
    n_checks++; if (dv_cnt - c0 !== 1) begin n_fail++; $display("FAIL gaps_pulse_count: got %0d expected 1", dv_cnt - c0); end
  endtask

  task automatic test_abort();
    logic [W-1:0] exp;
    int c0;
    c0 = dv_cnt;
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    send_data(8'hFF);
    send_parity(8'hFF, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (data_out_e !== exp) begin n_fail++; $display("FAIL abort_data: got %h expected %h", data_out_e, exp); end
    n_checks++; if (parity_err_e !== 1'b0) begin n_fail++; $display("FAIL abort_perr: got %b expected 0", parity_err_e); end
    tick();
    n_checks++; if (dv_cnt - c0 !== 1) begin n_fail++; $display("FAIL abort_pulse_count: got %0d expected 1", dv_cnt - c0); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp;
    int c0;
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    // a valid sof during reset must not start a frame
    rst = 1'b1; sin = 1'b1; sin_valid = 1'b1; sof = 1'b1;
    tick();
    rst = 1'b0; sin_valid = 1'b0; sof = 1'b0;
    exp_ec_e = 0; exp_ec_o = 0;
    n_checks++; if (data_out_e !== 8'h00) begin n_fail++; $display("FAIL rstmid_data_out: got %h expected 00", data_out_e); end
    n_checks++; if (data_valid_e !== 1'b0) begin n_fail++; $display("FAIL rstmid_dv: got %b expected 0", data_valid_e); end
    n_checks++; if (parity_err_e !== 1'b0) begin n_fail++; $display("FAIL rstmid_perr: got %b expected 0", parity_err_e); end
    n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy_e); end
    n_checks++; if (err_cnt_e !== 8'd0) begin n_fail++; $display("FAIL rstmid_err_cnt: got %0d expected 0", err_cnt_e); end
    c0 = dv_cnt;
    send_data(8'h81);
    send_parity(8'h81, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (data_out_e !== exp) begin n_fail++; $display("FAIL rstmid_data: got %h expected %h", data_out_e, exp); end
    n_checks++; if (parity_err_e !== 1'b0) begin n_fail++; $display("FAIL rstmid_perr_after: got %b expected 0", parity_err_e); end
    tick();
    n_checks++; if (dv_cnt - c0 !== 1) begin n_fail++; $display("FAIL rstmid_pulse_count: got %0d expected 1", dv_cnt - c0); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp;
    send_data(8'h5A);
    send_parity(8'h5A, 1'b0);
    exp = exp_q.pop_front();
    n_checks++; if (data_valid_e !== 1'b1 || data_out_e !== exp) begin n_fail++; $display("FAIL b2b_first: got dv=%b data=%h expected dv=1 data=%h", data_valid_e, data_out_e, exp); end
    send_data(8'h96);
    n_checks++; if (busy_e !== 1'b1 || data_valid_e !== 1'b0) begin n_fail++; $display("FAIL b2b_second_busy: got busy=%b dv=%b expected busy=1 dv=0", busy_e, data_valid_e); end
    send_parity(8'h96, 1'b1);
    exp = exp_q.pop_front();
    n_checks++; if (data_out_e !== exp) begin n_fail++; $display("FAIL b2b_second_data: got %h expected %h", data_out_e, exp); end
    n_checks++; if (parity_err_e !== 1'b1) begin n_fail++; $display("FAIL b2b_second_perr: got %b expected 1", parity_err_e); end
    tick();
    n_checks++; if (err_cnt_e !== ec(exp_ec_e)) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d expected %0d", err_cnt_e, ec(exp_ec_e)); end
  endtask

  task automatic test_odd();
    send_data(8'h01);
    send_parity(8'h01, 1'b0);
    void'(exp_q.pop_front());
    n_checks++; if (parity_err_o !== 1'b0) begin n_fail++; $display("FAIL odd_p0_odd: got %b expected 0", parity_err_o); end
    n_checks++; if (parity_err_e !== 1'b1) begin n_fail++; $display("FAIL odd_p0_even: got %b expected 1", parity_err_e); end
    n_checks++; if (data_out_o !== 8'h01) begin n_fail++; $display("FAIL odd_data: got %h expected 01", data_out_o); end
    send_data(8'h01);
    send_parity(8'h01, 1'b1);
    void'(exp_q.pop_front());
    n_checks++; if (parity_err_o !== 1'b1) begin n_fail++; $display("FAIL odd_p1_odd: got %b expected 1", parity_err_o); end
    n_checks++; if (parity_err_e !== 1'b0) begin n_fail++; $display("FAIL odd_p1_even: got %b expected 0", parity_err_e); end
    tick();
    n_checks++; if (err_cnt_o !== ec(exp_ec_o)) begin n_fail++; $display("FAIL odd_err_cnt: got %0d expected %0d", err_cnt_o, ec(exp_ec_o)); end
  endtask

  task automatic test_err_saturate();
    logic [W-1:0] exp;
    for (int f = 0; f < 260; f++) begin
      send_data(8'h01);
      send_parity(8'h01, 1'b1);
      exp = exp_q.pop_front();
      n_checks++; if (data_out_o !== exp || parity_err_o !== 1'b1) begin n_fail++; $display("FAIL sat_frame %0d: got data=%h perr=%b expected data=%h perr=1", f, data_out_o, parity_err_o, exp); end
    end
    tick();
    n_checks++; if (err_cnt_o !== (ERRCNT ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL sat_err_cnt: got %0d expected %0d", err_cnt_o, ERRCNT ? 255 : 0); end
    n_checks++; if (err_cnt_e !== ec(exp_ec_e)) begin n_fail++; $display("FAIL sat_even_err_cnt: got %0d expected %0d", err_cnt_e, ec(exp_ec_e)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_error();
    test_gaps();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_odd();
    test_err_saturate();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
